i2c_slave_regmap: RTL
=====================

I2C_SLAVE_REGMAP -- requirements
Module: I2C_slave_regmap

Interface
REQ-001 SHALL have parameter REG_RST, default 64'h0, giving the reset contents of reg0..reg7 (reg n = bits [8n+7:8n]).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port slave_en  input  1  block enable; low forces IDLE.
REQ-005 SHALL have port rd_reg_full  input  1  slave holds a received byte.
REQ-006 SHALL have port byte_rd_i  input  8  received byte from the slave.
REQ-007 SHALL have port rd_clr  output  1  one-cycle pulse: received byte consumed.
REQ-008 SHALL have port wr_reg_empty  input  1  slave input register free.
REQ-009 SHALL have port wr_rdy  output  1  one-cycle pulse: byte_wr_o valid for the slave.
REQ-010 SHALL have port byte_wr_o  output  8  byte to transmit.
REQ-011 SHALL have port addr_match, trans_dir, get_nack, trans_stop, bus_err  input  1 each  slave status.
REQ-012 SHALL have port host_we  input  1  local register write strobe.
REQ-013 SHALL have port host_idx  input  3  local write index.
REQ-014 SHALL have port host_data  input  8  local write data.
REQ-015 SHALL have port regs_o  output  64  register file contents.
REQ-016 SHALL have port reg_wr_pulse  output  1  one-cycle pulse per I2C register write.
REQ-017 SHALL have port reg_wr_idx  output  3  index of the last I2C-written register.
REQ-018 SHALL have port ptr_o  output  3  current register pointer.

Function
REQ-019 SHALL use states IDLE, DIR, RX_PTR, RX_DATA, TX_LOAD, TX_HOLD.
REQ-020 SHALL register addr_match; its rising edge (addr_rise) SHALL move to DIR from any state.
REQ-021 DIR SHALL last exactly one cycle, then go to RX_PTR if trans_dir=0, else TX_LOAD.
REQ-022 RX_PTR: on accepted byte, ptr <= byte_rd_i[2:0], pulse rd_clr, go to RX_DATA; bits [7:3] are ignored.
REQ-023 RX_DATA: on accepted byte, reg[ptr] <= byte_rd_i, pulse reg_wr_pulse, reg_wr_idx <= ptr, ptr <= ptr+1 mod 8, pulse rd_clr.
REQ-024 Accepted byte SHALL mean rd_reg_full=1 with no rd_clr in the previous cycle, so one byte is never consumed twice.
REQ-025 TX_LOAD: when wr_reg_empty=1, byte_wr_o <= reg[ptr], pulse wr_rdy, ptr <= ptr+1 mod 8, go to TX_HOLD.
REQ-026 TX_HOLD SHALL last one cycle, then return to TX_LOAD.
REQ-027 get_nack=1 in TX_LOAD or TX_HOLD SHALL go to IDLE; if wr_reg_empty=0 (prefetched byte unsent) ptr <= ptr-1 mod 8.
REQ-028 Transition priority: slave_en=0 > bus_err > addr_rise > trans_stop > state rules; the first three and trans_stop SHALL all go to IDLE except addr_rise (DIR).
REQ-029 ptr and registers SHALL persist across transactions; only reset alters them outside the rules above.
REQ-030 host_we SHALL write reg[host_idx] <= host_data; same-cycle same-index I2C write SHALL win and host write SHALL be dropped.
REQ-031 rd_clr, wr_rdy, reg_wr_pulse SHALL be registered and never high two consecutive cycles.
REQ-032 Latency: accepted byte -> reg update and rd_clr one cycle later; wr_reg_empty=1 in TX_LOAD -> wr_rdy one cycle later.

Reset
REQ-033 On rst_n=0: state IDLE, regs_o=REG_RST, ptr 0, byte_wr_o 8'h00, reg_wr_idx 0, all pulses 0, registered addr_match 0.
REQ-034 Reset mid-transaction SHALL abort immediately with no further pulses until a new addr_rise.

Verification
REQ-035 Write: addr_rise, trans_dir=0, bytes 8'h02,8'hA5,8'h3C -> reg2=A5, reg3=3C, ptr_o=4, two reg_wr_pulse, three rd_clr.
REQ-036 Wrap: pointer 8'h07 then bytes 11,22 -> reg7=11, reg0=22, ptr_o=1.
REQ-037 Read: regs 5,6=77,88, ptr=5, trans_dir=1, wr_reg_empty toggling -> byte_wr_o 77 then 88, ptr_o=7.
REQ-038 NACK with prefetched byte pending (wr_reg_empty=0) after loads at 5,6 -> IDLE, ptr_o=6.
REQ-039 Repeated start: pointer 8'h03, addr_rise with trans_dir=1 -> DIR then TX_LOAD, first byte_wr_o=reg3.
REQ-040 Collision: host_we idx 4 data FF same cycle as I2C write 4 data 12 -> reg4=12; bus_err mid-RX_DATA -> IDLE, no rd_clr.

Source files
------------

// File: rtl/i2c_slave_regmap.sv
// Register-map front end for a byte-level I2C slave: eight 8-bit registers behind an
// auto-incrementing pointer, written by the I2C master or locally by the host.
module i2c_slave_regmap #(
    parameter logic [63:0] REG_RST = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        slave_en,
    input  logic        rd_reg_full,
    input  logic [7:0]  byte_rd_i,
    output logic        rd_clr,
    input  logic        wr_reg_empty,
    output logic        wr_rdy,
    output logic [7:0]  byte_wr_o,
    input  logic        addr_match,
    input  logic        trans_dir,
    input  logic        get_nack,
    input  logic        trans_stop,
    input  logic        bus_err,
    input  logic        host_we,
    input  logic [2:0]  host_idx,
    input  logic [7:0]  host_data,
    output logic [63:0] regs_o,
    output logic        reg_wr_pulse,
    output logic [2:0]  reg_wr_idx,
    output logic [2:0]  ptr_o
);

    localparam int unsigned NREGS = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned PW    = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DIR     = 3'd1,
        RX_PTR  = 3'd2,
        RX_DATA = 3'd3,
        TX_LOAD = 3'd4,
        TX_HOLD = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]   regs_q [NREGS];
    logic [DW-1:0]   byte_wr_d;
    logic [PW-1:0]   wr_idx_d;
    logic            rd_clr_d, wr_rdy_d, i2c_we_d;
    logic            addr_q;
    logic            addr_rise;
    logic            byte_accept;

    assign addr_rise   = addr_match & ~addr_q;
    // A byte is not re-accepted while the clear for it is still in flight.
    assign byte_accept = rd_reg_full & ~rd_clr;

    // Next-state and registered-output intent
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        byte_wr_d = byte_wr_o;
        wr_idx_d  = reg_wr_idx;
        rd_clr_d  = 1'b0;
        wr_rdy_d  = 1'b0;
        i2c_we_d  = 1'b0;
        if (!slave_en || bus_err) begin
            state_d = IDLE;
        end else if (addr_rise) begin
            state_d = DIR;
        end else if (trans_stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                DIR:  state_d = trans_dir ? TX_LOAD : RX_PTR;
                RX_PTR: begin
                    if (byte_accept) begin
                        ptr_d    = byte_rd_i[PW-1:0];
                        rd_clr_d = 1'b1;
                        state_d  = RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (byte_accept) begin
                        i2c_we_d = 1'b1;
                        wr_idx_d = ptr_q;
                        ptr_d    = PW'(ptr_q + PW'(1));
                        rd_clr_d = 1'b1;
                    end
                end
                TX_LOAD, TX_HOLD: begin
                    if (get_nack) begin
                        state_d = IDLE;
                        // Undo the prefetch that the master never collected
                        if (!wr_reg_empty) ptr_d = PW'(ptr_q - PW'(1));
                    end else if (state_q == TX_HOLD) begin
                        state_d = TX_LOAD;
                    end else if (wr_reg_empty) begin
                        byte_wr_d = regs_q[ptr_q];
                        wr_rdy_d  = 1'b1;
                        ptr_d     = PW'(ptr_q + PW'(1));
                        state_d   = TX_HOLD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, pointer and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            addr_q       <= 1'b0;
            byte_wr_o    <= '0;
            reg_wr_idx   <= '0;
            rd_clr       <= 1'b0;
            wr_rdy       <= 1'b0;
            reg_wr_pulse <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            addr_q       <= addr_match;
            byte_wr_o    <= byte_wr_d;
            reg_wr_idx   <= wr_idx_d;
            rd_clr       <= rd_clr_d;
            wr_rdy       <= wr_rdy_d;
            reg_wr_pulse <= i2c_we_d;
        end
    end

    // Register file; an I2C write to the same index beats the host write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= REG_RST[DW*i +: DW];
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i2c_we_d && (ptr_q == PW'(i))) begin
                    regs_q[i] <= byte_rd_i;
                end else if (host_we && (host_idx == PW'(i))) begin
                    regs_q[i] <= host_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regs_o
        assign regs_o[DW*g +: DW] = regs_q[g];
    end

    assign ptr_o = ptr_q;

endmodule
